register_file_rename: RTL

REGISTER_FILE_RENAME -- requirements
Module: register_file_rename

---
 rtl/register_file_rename_if.sv | 41 ++++
 rtl/register_file_rename.sv | 96 +++++++++
 2 files changed

// File: rtl/register_file_rename_if.sv
// Bundle of rename-table request, commit and read-back signals.
// The slave modport is the register file; the master modport is the pipeline driving it.
interface register_file_rename_if #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int ROB_WIDTH = 4
);
    localparam int RID_W = $clog2(REG_COUNT);
    localparam int CNT_W = RID_W + 1;

    logic                 rdy_in;
    logic                 issue_in;
    logic [RID_W-1:0]     rs1_id;
    logic [RID_W-1:0]     rs2_id;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
    logic [ROB_WIDTH-1:0] rs1_tag;
    logic [ROB_WIDTH-1:0] rs2_tag;
    logic                 rs1_valid;
    logic                 rs2_valid;
    logic [RID_W-1:0]     rd_id;
    logic [ROB_WIDTH-1:0] rd_tag;
    logic                 commit_in;
    logic [RID_W-1:0]     commit_rd_id;
    logic [ROB_WIDTH-1:0] commit_tag;
    logic [XLEN-1:0]      commit_value;
    logic                 flush_in;
    logic [CNT_W-1:0]     pending_cnt;

    modport master (
        output rdy_in, issue_in, rs1_id, rs2_id, rd_id, rd_tag,
               commit_in, commit_rd_id, commit_tag, commit_value, flush_in,
        input  rs1_value, rs2_value, rs1_tag, rs2_tag, rs1_valid, rs2_valid, pending_cnt
    );

    modport slave (
        input  rdy_in, issue_in, rs1_id, rs2_id, rd_id, rd_tag,
               commit_in, commit_rd_id, commit_tag, commit_value, flush_in,
        output rs1_value, rs2_value, rs1_tag, rs2_tag, rs1_valid, rs2_valid, pending_cnt
    );
endinterface

// File: rtl/register_file_rename.sv
// Architectural register file with per-register rename tags and ready bits.
// Commits are forwarded to same-cycle reads; flush marks every register ready again.
module register_file_rename #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int ROB_WIDTH = 4
) (
    input logic                   clk_in,
    input logic                   rst_in,
    register_file_rename_if.slave bus
);
    localparam int RID_W = $clog2(REG_COUNT);
    localparam int CNT_W = RID_W + 1;

    logic [XLEN-1:0]      value_q [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
    logic [REG_COUNT-1:0] valid_q;
    logic [CNT_W-1:0]     pending_q;

    logic                 rename_hit;
    logic                 commit_hit;
    logic [REG_COUNT-1:0] valid_next;
    logic [CNT_W-1:0]     pending_next;
    logic                 match1;
    logic                 match2;

    always_comb begin
        rename_hit = bus.issue_in && bus.rdy_in && (bus.rd_id != '0) && !bus.flush_in;
        commit_hit = bus.commit_in && (bus.commit_rd_id != '0);
        valid_next = valid_q;
        if (bus.flush_in) begin
            valid_next = '1;
        end else begin
            // A same-cycle rename of the committing register keeps it pending.
            if (commit_hit && !valid_q[bus.commit_rd_id]
                && (tag_q[bus.commit_rd_id] == bus.commit_tag)
                && !(rename_hit && (bus.rd_id == bus.commit_rd_id)))
                valid_next[bus.commit_rd_id] = 1'b1;
            if (rename_hit)
                valid_next[bus.rd_id] = 1'b0;
        end
        valid_next[0] = 1'b1;
        pending_next = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (!valid_next[i])
                pending_next = pending_next + CNT_W'(1);
        end
    end

    always_comb begin
        match1 = bus.commit_in && !valid_q[bus.rs1_id]
                 && (tag_q[bus.rs1_id] == bus.commit_tag) && (bus.rs1_id != '0);
        match2 = bus.commit_in && !valid_q[bus.rs2_id]
                 && (tag_q[bus.rs2_id] == bus.commit_tag) && (bus.rs2_id != '0);

        if (bus.rs1_id == '0) begin
            bus.rs1_value = '0;
            bus.rs1_tag   = '0;
            bus.rs1_valid = 1'b1;
        end else begin
            bus.rs1_value = match1 ? bus.commit_value : value_q[bus.rs1_id];
            bus.rs1_tag   = tag_q[bus.rs1_id];
            bus.rs1_valid = match1 | valid_q[bus.rs1_id];
        end

        if (bus.rs2_id == '0) begin
            bus.rs2_value = '0;
            bus.rs2_tag   = '0;
            bus.rs2_valid = 1'b1;
        end else begin
            bus.rs2_value = match2 ? bus.commit_value : value_q[bus.rs2_id];
            bus.rs2_tag   = tag_q[bus.rs2_id];
            bus.rs2_valid = match2 | valid_q[bus.rs2_id];
        end
    end

    assign bus.pending_cnt = pending_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            valid_q   <= '1;
            pending_q <= '0;
        end else if (bus.rdy_in) begin
            if (commit_hit)
                value_q[bus.commit_rd_id] <= bus.commit_value;
            if (rename_hit)
                tag_q[bus.rd_id] <= bus.rd_tag;
            valid_q   <= valid_next;
            pending_q <= pending_next;
        end
    end
endmodule
